// File: rtl/jt053246_pkg.sv
// Shared definitions for the k053246 draw-request path.
//   JW        : width of one resolved sprite tile job
//   obj_job_t : job layout, MSB first
//   drq_state_t : issue FSM states of the draw-request queue
package jt053246_pkg;

    localparam int JW = 56;

    typedef struct packed {
        logic [15:0] code;
        logic [9:0]  attr;
        logic        hflip;
        logic        vflip;
        logic [8:0]  hpos;
        logic [3:0]  ysub;
        logic [11:0] hzoom;
        logic        hz_keep;
        logic [1:0]  shd;
    } obj_job_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GUARD,
        WAIT
    } drq_state_t;

endpackage

// File: rtl/jtframe_dual_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered
// output. Both ports advance only on cen.
//   clk, cen          : clock and clock enable
//   we, wr_addr, wr_data : write port
//   re, rd_addr, rd_data : read port, rd_data updates the cycle after re
module jtframe_dual_ram #(
    parameter int AW = 2,
    parameter int DW = 56
) (
    input  logic          clk,
    input  logic          cen,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          re,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // NOTE: the array and its read register have no reset so the tools can
    // map them onto block RAM; nothing reads a slot before it is written.
    always_ff @(posedge clk) begin
        if (cen && we) mem[wr_addr] <= wr_data;
        if (cen && re) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/jt053246_drq.sv
// Draw-request queue between the object-table scanner and the line drawer.
// Buffers up to DEPTH jobs, issues them with a start/busy handshake and
// discards stale jobs on every rising edge of hs.
//   clk, rstn, cen     : clock, async active-low reset, clock enable
//   hs                 : horizontal sync, rising edge = line boundary
//   in_start, in_job   : push from the scanner; in_busy = queue full
//   dr_start, dr_job   : one-cen issue pulse and job to the drawer
//   dr_busy            : drawer busy
//   level, drops       : occupancy and saturating discarded-job count
module jt053246_drq
    import jt053246_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int JW    = jt053246_pkg::JW
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   cen,
    input  logic                   hs,
    input  logic                   in_start,
    input  logic [JW-1:0]          in_job,
    output logic                   in_busy,
    output logic                   dr_start,
    output logic [JW-1:0]          dr_job,
    input  logic                   dr_busy,
    output logic [$clog2(DEPTH):0] level,
    output logic [7:0]             drops
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]   wptr, rptr;
    logic          hs_l;
    logic          full, empty, flush, push, pop;
    logic [AW+1:0] lost;
    logic [8:0]    drops_sum;
    logic [JW-1:0] ram_q, job_r;
    drq_state_t    state, state_nxt;

    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty   = (wptr == rptr);
    assign flush   = hs && !hs_l;
    assign push    = in_start && !full && !flush;
    assign pop     = (state == ISSUE);
    assign level   = wptr - rptr;
    assign in_busy = full;

    // The head is presented straight from the RAM register during ISSUE and
    // held in job_r afterwards, so dr_job only ever changes in ISSUE.
    assign dr_start = pop;
    assign dr_job   = pop ? ram_q : job_r;

    jtframe_dual_ram #(.AW(AW), .DW(JW)) u_ram (
        .clk     (clk),
        .cen     (cen),
        .we      (push),
        .wr_addr (wptr[AW-1:0]),
        .wr_data (in_job),
        .re      (state == IDLE || state == WAIT),
        .rd_addr (rptr[AW-1:0]),
        .rd_data (ram_q)
    );

    // Jobs lost this cycle: everything waiting at a flush (minus the head
    // being issued right now, which still goes out), plus a rejected push.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned (which would infer a latch).
        lost = '0;
        if (flush) lost = {1'b0, level} - {{(AW+1){1'b0}}, pop};
        if (in_start && (flush || full)) lost = lost + {{(AW+1){1'b0}}, 1'b1};
        drops_sum = {1'b0, drops} + 9'(lost);
    end

    // A flush leaves the queue empty, so no new issue starts on that cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!empty && !flush) state_nxt = ISSUE;
            ISSUE:   state_nxt = GUARD;
            GUARD:   state_nxt = WAIT;
            WAIT:    if (!dr_busy) state_nxt = (!empty && !flush) ? ISSUE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            wptr  <= '0;
            rptr  <= '0;
            hs_l  <= 1'b0;
            job_r <= '0;
            drops <= '0;
        end else if (cen) begin
            state <= state_nxt;
            hs_l  <= hs;
            if (pop) job_r <= ram_q;
            if (flush) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (push) wptr <= wptr + PTR_ONE;
                if (pop)  rptr <= rptr + PTR_ONE;
            end
            drops <= drops_sum[8] ? 8'hFF : drops_sum[7:0];
        end
    end

endmodule
